keypad_scanner: RTL and testbench

Row-scanning front end for the 4x4 matrix keypad. Drives one-hot rows, synchronizes the column inputs and freezes the scan on a pressed key. It also feeds the key-activity level into the debouncer's `btn` input and consumes the debouncer's single-cycle `tecla` pulse. On each accepted press it queues a 4-bit key code in a small FIFO for the downstream consumer, using a valid/ready handshake.

---
 rtl/keypad_scanner.sv | 241 ++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Row-scanning front end for a 4x4 matrix keypad. The block drives one-hot
// rows and synchronizes the raw column inputs. When a key is seen it freezes
// the scan and reports key activity to an external debouncer. Each debounced
// press pulse it receives pushes a 4-bit key code into a small FIFO, which is
// read through a valid/ready handshake.
//
// Parameters
//   SCAN_DIV    clk cycles per row dwell; also the quiet time that ends a
//               HOLD (bounce) or RELEASE phase. Must be >= 2.
//   FIFO_DEPTH  key-code queue entries. Must be a power of 2 and >= 2.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset, released synchronously
//   col[3:0]   in   raw keypad columns, active-high, asynchronous
//   row[3:0]   out  one-hot row drive, active-high
//   key_raw    out  registered key-activity level (to debouncer btn)
//   tecla      in   single-cycle debounced press pulse (from debouncer)
//   key_code   out  FIFO head code = row_idx*4 + col_idx
//   key_valid  out  FIFO non-empty
//   key_ready  in   consumer accepts the head while key_valid is high
//   overflow   out  one-cycle pulse after a press dropped on a full FIFO
//
// Build option
//   KEYPAD_MULTIKEY_REJECT_EN  when defined, a press seen with more than one
//                              column active is not queued. The FSM still
//                              waits for release. When undefined, the
//                              lowest-index column wins.
// -----------------------------------------------------------------------------
module keypad_scanner #(
   parameter int unsigned SCAN_DIV   = 1000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic       key_raw,
   input  logic       tecla,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       overflow
);

   localparam int unsigned   CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam int unsigned   AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_HOLD,
      ST_RELEASE
   } state_t;

   // ---------------------------------------------------------------------------
   // Column synchronizer
   // ---------------------------------------------------------------------------
   logic [3:0] r_col_meta;
   logic [3:0] r_col_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_col_meta <= '0;
         r_col_s    <= '0;
      end else begin
         r_col_meta <= col;
         r_col_s    <= r_col_meta;
      end
   end

   // ---------------------------------------------------------------------------
   // Scan FSM state
   // ---------------------------------------------------------------------------
   state_t          r_state;
   logic [3:0]      r_row;
   logic [CW-1:0]   r_cnt;
   logic            r_key_raw;

   logic            w_col_any;
   logic            w_cnt_done;
   logic [1:0]      w_col_idx;
   logic [1:0]      w_row_idx;
   logic [3:0]      w_code;
   logic            w_push;

   assign w_col_any  = |r_col_s;
   assign w_cnt_done = (r_cnt == CNT_MAX);

   // Lowest set column wins.
   always_comb begin
      w_col_idx = 2'd0;
      if (r_col_s[0])      w_col_idx = 2'd0;
      else if (r_col_s[1]) w_col_idx = 2'd1;
      else if (r_col_s[2]) w_col_idx = 2'd2;
      else if (r_col_s[3]) w_col_idx = 2'd3;
   end

   always_comb begin
      w_row_idx = 2'd0;
      case (r_row)
         4'b0001: w_row_idx = 2'd0;
         4'b0010: w_row_idx = 2'd1;
         4'b0100: w_row_idx = 2'd2;
         4'b1000: w_row_idx = 2'd3;
         default: w_row_idx = 2'd0;
      endcase
   end

   // row_idx*4 + col_idx is a plain concatenation and can never exceed 15.
   assign w_code = {w_row_idx, w_col_idx};

`ifdef KEYPAD_MULTIKEY_REJECT_EN
   logic w_col_multi;
   // Clearing the lowest set bit leaves a remainder only if two or more
   // columns are active.
   assign w_col_multi = ((r_col_s & (r_col_s - 4'd1)) != 4'd0);
   assign w_push      = (r_state == ST_HOLD) && tecla && !w_col_multi;
`else
   assign w_push      = (r_state == ST_HOLD) && tecla;
`endif

   // r_cnt serves as the row-dwell counter in SCAN and as the
   // quiet-column counter in HOLD/RELEASE. Every state change clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_SCAN;
         r_row     <= 4'b0001;
         r_cnt     <= '0;
         r_key_raw <= 1'b0;
      end else begin
         case (r_state)
            ST_SCAN: begin
               r_key_raw <= 1'b0;
               if (w_col_any) begin
                  r_state <= ST_HOLD;
                  r_cnt   <= '0;
               end else if (w_cnt_done) begin
                  r_cnt <= '0;
                  r_row <= {r_row[2:0], r_row[3]};
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            ST_HOLD: begin
               r_key_raw <= w_col_any;
               if (tecla) begin
                  r_state <= ST_RELEASE;
                  r_cnt   <= '0;
               end else if (w_col_any) begin
                  r_cnt <= '0;
               end else if (w_cnt_done) begin
                  // Bounce only: resume scanning from the frozen row.
                  r_state <= ST_SCAN;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            ST_RELEASE: begin
               r_key_raw <= w_col_any;
               if (w_col_any) begin
                  r_cnt <= '0;
               end else if (w_cnt_done) begin
                  r_state <= ST_SCAN;
                  r_cnt   <= '0;
                  r_row   <= {r_row[2:0], r_row[3]};
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            default: begin
               r_state   <= ST_SCAN;
               r_row     <= 4'b0001;
               r_cnt     <= '0;
               r_key_raw <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Key-code FIFO
   // ---------------------------------------------------------------------------
   logic [3:0]  r_mem [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        r_overflow;

   logic        w_empty;
   logic        w_full;
   logic        w_pop;
   logic        w_wr;

   // Pointers carry one extra wrap bit to distinguish full from empty.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                    (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_pop   = !w_empty && key_ready;
   // When full, a push is accepted only if a pop frees the head slot in the
   // same cycle. The head is read before the edge that overwrites it.
   assign w_wr    = w_push && (!w_full || w_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_code;
            r_wr_ptr                <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         r_overflow <= w_push && !w_wr;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign row       = r_row;
   assign key_raw   = r_key_raw;
   assign key_code  = r_mem[r_rd_ptr[AW-1:0]];
   assign key_valid = !w_empty;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Directed bench for keypad_scanner (SCAN_DIV = 8, FIFO_DEPTH = 4). A vector
// table covers the scan rotation and a single press. Hand-written sequences
// cover bounce, queue overflow, a push/pop on a full queue, multi-key presses
// and a mid-operation reset. Inputs change 1 time unit after a rising edge.
// Outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

   localparam int unsigned SD = 8;

   logic       clk;
   logic       rst;
   logic [3:0] col;
   logic [3:0] row;
   logic       key_raw;
   logic       tecla;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic       overflow;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   keypad_scanner #(
      .SCAN_DIV   (SD),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .col       (col),
      .row       (row),
      .key_raw   (key_raw),
      .tecla     (tecla),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .overflow  (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      int unsigned ncyc;
      logic [3:0]  col;
      logic        tecla;
      logic        ready;
      logic [3:0]  exp_row;
      logic        exp_raw;
      logic        exp_valid;
      logic [3:0]  exp_code;
   } vec_t;

   vec_t vecs [15];

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] rot(input logic [3:0] r);
      return {r[2:0], r[3]};
   endfunction

   // Starts from SCAN with a fresh dwell count at row exp_row. Holds the key
   // until HOLD, then pulses tecla and releases. It then waits out the
   // release time and checks that the row has advanced.
   task automatic press(input logic [3:0] c, input logic rdy_t, input logic rdy_after,
                        input logic exp_v, input logic [3:0] exp_head,
                        input logic exp_ovf, input logic [3:0] exp_row);
      col = c;
      tick(4);
      chk("hold_row", row, exp_row);
      chk("hold_raw", key_raw, 1);
      key_ready = rdy_t;
      tecla     = 1'b1;
      tick(1);
      tecla     = 1'b0;
      col       = 4'b0000;
      key_ready = rdy_after;
      chk("push_valid", key_valid, exp_v);
      if (exp_v) chk("push_head", key_code, exp_head);
      chk("ovf_pulse", overflow, exp_ovf);
      tick(1);
      chk("ovf_clear", overflow, 0);
      tick(8);
      chk("release_row", row, exp_row);
      tick(1);
      chk("release_adv", row, rot(exp_row));
   endtask

   // Waits for the row to step onto target, so the dwell count is zero.
   task automatic wait_row(input logic [3:0] target);
      logic [3:0] prev;
      bit         hit;
      hit = 1'b0;
      for (int i = 0; i < 5 * SD; i++) begin
         prev = row;
         tick(1);
         if (row == target && prev != target) begin
            hit = 1'b1;
            break;
         end
      end
      chk("wait_row", hit, 1);
   endtask

   initial begin
      logic [3:0] drain [4];

      //           ncyc col      t     rdy   row      raw   vld   code
      vecs[0]  = '{7,  4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 4'h0};
      vecs[1]  = '{1,  4'b0000, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 4'h0};
      vecs[2]  = '{8,  4'b0000, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 4'h0};
      vecs[3]  = '{8,  4'b0000, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 4'h0};
      vecs[4]  = '{8,  4'b0000, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 4'h0};
      vecs[5]  = '{8,  4'b0000, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 4'h0};
      vecs[6]  = '{3,  4'b0100, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 4'h0};
      vecs[7]  = '{1,  4'b0100, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 4'h0};
      vecs[8]  = '{10, 4'b0100, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 4'h0};
      vecs[9]  = '{1,  4'b0100, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1, 4'h6};
      vecs[10] = '{1,  4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 4'h0};
      vecs[11] = '{1,  4'b0000, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 4'h0};
      vecs[12] = '{1,  4'b0000, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 4'h0};
      vecs[13] = '{6,  4'b0000, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 4'h0};
      vecs[14] = '{1,  4'b0000, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 4'h0};

      drain[0] = 4'd1;
      drain[1] = 4'd6;
      drain[2] = 4'd11;
      drain[3] = 4'd2;

      rst       = 1'b1;
      col       = 4'b0000;
      tecla     = 1'b0;
      key_ready = 1'b1;
      #2 rst    = 1'b0;
      tick(2);
      chk("rst_row",   row,       4'b0001);
      chk("rst_raw",   key_raw,   0);
      chk("rst_code",  key_code,  0);
      chk("rst_valid", key_valid, 0);
      chk("rst_ovf",   overflow,  0);
      rst = 1'b1;

      // Scan rotation and one press (row 1, col 2 -> code 6).
      for (int i = 0; i < 15; i++) begin
         col       = vecs[i].col;
         tecla     = vecs[i].tecla;
         key_ready = vecs[i].ready;
         tick(vecs[i].ncyc);
         chk($sformatf("vec%0d_row", i),   row,       vecs[i].exp_row);
         chk($sformatf("vec%0d_raw", i),   key_raw,   vecs[i].exp_raw);
         chk($sformatf("vec%0d_valid", i), key_valid, vecs[i].exp_valid);
         if (vecs[i].exp_valid) chk($sformatf("vec%0d_code", i), key_code, vecs[i].exp_code);
         chk($sformatf("vec%0d_ovf", i),   overflow,  0);
      end
      tecla = 1'b0;

      // tecla while scanning is ignored. Bounce in HOLD returns to SCAN on
      // the same row without pushing anything.
      tecla = 1'b1;
      tick(1);
      tecla = 1'b0;
      chk("tecla_scan_valid", key_valid, 0);
      col = 4'b0010;
      tick(4);
      chk("bounce_hold_raw", key_raw, 1);
      chk("bounce_hold_row", row, 4'b0100);
      col = 4'b0000;
      tick(2);
      col = 4'b0010;
      tick(2);
      col = 4'b0000;
      tick(10);
      chk("bounce_row",   row,       4'b0100);
      chk("bounce_valid", key_valid, 0);
      chk("bounce_raw",   key_raw,   0);
      tick(7);
      chk("bounce_dwell", row, 4'b0100);
      tick(1);
      chk("bounce_resume", row, 4'b1000);

      // Five presses into a 4-deep queue with no consumer. Then a sixth
      // press whose push coincides with a pop on the full queue.
      key_ready = 1'b0;
      press(4'b0001, 1'b0, 1'b0, 1'b1, 4'd12, 1'b0, 4'b1000);
      press(4'b0010, 1'b0, 1'b0, 1'b1, 4'd12, 1'b0, 4'b0001);
      press(4'b0100, 1'b0, 1'b0, 1'b1, 4'd12, 1'b0, 4'b0010);
      press(4'b1000, 1'b0, 1'b0, 1'b1, 4'd12, 1'b0, 4'b0100);
      press(4'b0010, 1'b0, 1'b0, 1'b1, 4'd12, 1'b1, 4'b1000);
      press(4'b0100, 1'b1, 1'b0, 1'b1, 4'd1,  1'b0, 4'b0001);
      key_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain%0d_valid", i), key_valid, 1);
         chk($sformatf("drain%0d_code", i),  key_code,  drain[i]);
         tick(1);
      end
      chk("drain_empty", key_valid, 0);
      chk("drain_ovf",   overflow,  0);

      // Columns 0 and 3 together on row 3.
      wait_row(4'b1000);
`ifdef KEYPAD_MULTIKEY_REJECT_EN
      press(4'b1001, 1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'b1000);
`else
      press(4'b1001, 1'b1, 1'b1, 1'b1, 4'd12, 1'b0, 4'b1000);
`endif
      chk("multi_empty", key_valid, 0);

      // Reset while in HOLD with two entries queued.
      key_ready = 1'b0;
      press(4'b0100, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 4'b0001);
      press(4'b1000, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 4'b0010);
      col = 4'b0001;
      tick(4);
      chk("pre_rst_raw",   key_raw,   1);
      chk("pre_rst_valid", key_valid, 1);
      chk("pre_rst_code",  key_code,  2);
      rst = 1'b0;
      #1;
      chk("mid_rst_row",   row,       4'b0001);
      chk("mid_rst_raw",   key_raw,   0);
      chk("mid_rst_code",  key_code,  0);
      chk("mid_rst_valid", key_valid, 0);
      chk("mid_rst_ovf",   overflow,  0);
      col = 4'b0000;
      tick(2);
      rst = 1'b1;
      tick(7);
      chk("post_rst_row",   row,       4'b0001);
      chk("post_rst_valid", key_valid, 0);
      chk("post_rst_ovf",   overflow,  0);
      tick(1);
      chk("post_rst_step",  row,       4'b0010);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
